// File: rtl/wm_pkg.sv
// Shared types and constants for the washing machine and its front panel.
package wm_pkg;

    typedef enum logic [1:0] {
        WM_LIGHT  = 2'b00,
        WM_NORMAL = 2'b01,
        WM_HEAVY  = 2'b10
    } wm_mode_e;

    localparam logic [3:0] WM_IDLE = 4'd0;

    typedef enum logic [1:0] {
        P_IDLE,
        P_ARM,
        P_RUN,
        P_DONE
    } panel_state_e;

    function automatic wm_mode_e next_mode(input wm_mode_e m);
        case (m)
            WM_LIGHT:  next_mode = WM_NORMAL;
            WM_NORMAL: next_mode = WM_HEAVY;
            default:   next_mode = WM_LIGHT;
        endcase
    endfunction

    function automatic logic [2:0] mode_led_of(input wm_mode_e m);
        case (m)
            WM_NORMAL: mode_led_of = 3'b010;
            WM_HEAVY:  mode_led_of = 3'b100;
            default:   mode_led_of = 3'b001;
        endcase
    endfunction

endpackage

// File: rtl/wm_control_panel_if.sv
// Panel-facing signal bundle: buttons and sensors in, machine controls and indicators out.
interface wm_control_panel_if;

    logic       btn_start;
    logic       btn_mode;
    logic       door_closed;
    logic [3:0] wm_state;
    logic       start;
    logic [1:0] mode;
    logic [2:0] mode_led;
    logic       door_lock;
    logic       busy;
    logic       done;
    logic       error;

    modport master (
        input  btn_start, btn_mode, door_closed, wm_state,
        output start, mode, mode_led, door_lock, busy, done, error
    );

    modport slave (
        output btn_start, btn_mode, door_closed, wm_state,
        input  start, mode, mode_led, door_lock, busy, done, error
    );

endinterface

// File: rtl/wm_debounce.sv
// Two-flop synchroniser plus stability filter for one raw push-button.
module wm_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // cnt counts consecutive samples that disagree with the accepted level
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync2;
                press <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/wm_control_panel.sv
// Front-panel sequencer: debounced START/MODE buttons, start pulse, door lock and status flags.
//
//   state  | meaning
//   P_IDLE | door unlocked, mode selectable, waiting for a start press
//   P_ARM  | start issued, waiting for the machine to leave idle
//   P_RUN  | machine running, panel inputs frozen
//   P_DONE | machine back to idle, door held locked for the unlock delay
module wm_control_panel
    import wm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int ARM_TIMEOUT     = 8,
    parameter int UNLOCK_DELAY    = 4
) (
    input  logic               clk,
    input  logic               reset,
    wm_control_panel_if.master pnl
);

    localparam int TMR_MAX = (ARM_TIMEOUT > UNLOCK_DELAY) ? ARM_TIMEOUT : UNLOCK_DELAY;
    localparam int TW      = $clog2(TMR_MAX + 1);
    localparam logic [TW-1:0] ARM_LOAD    = TW'(ARM_TIMEOUT);
    localparam logic [TW-1:0] UNLOCK_LOAD = TW'(UNLOCK_DELAY);
    localparam logic [TW-1:0] TMR_TC      = TW'(1);

    logic start_press, mode_press;
    logic start_level, mode_level;
    logic unused_levels;

    panel_state_e  state_q, state_d;
    wm_mode_e      mode_q, mode_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [2:0]    led_q;
    logic          start_q, start_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    logic          door_lock_q, door_lock_d;
    logic          busy_q, busy_d;
    logic          door_prev_q;

    wm_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
        .clk   (clk),
        .reset (reset),
        .raw   (pnl.btn_start),
        .level (start_level),
        .press (start_press)
    );

    wm_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
        .clk   (clk),
        .reset (reset),
        .raw   (pnl.btn_mode),
        .level (mode_level),
        .press (mode_press)
    );

    assign unused_levels = start_level ^ mode_level;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= P_IDLE;
            mode_q      <= WM_LIGHT;
            tmr_q       <= '0;
            led_q       <= 3'b001;
            start_q     <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            door_lock_q <= 1'b0;
            busy_q      <= 1'b0;
            door_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            tmr_q       <= tmr_d;
            led_q       <= mode_led_of(mode_d);
            start_q     <= start_d;
            done_q      <= done_d;
            error_q     <= error_d;
            door_lock_q <= door_lock_d;
            busy_q      <= busy_d;
            door_prev_q <= pnl.door_closed;
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        tmr_d   = (tmr_q != '0) ? tmr_q - 1'b1 : '0;
        start_d = 1'b0;
        done_d  = 1'b0;
        error_d = error_q;
        case (state_q)
            P_IDLE: begin
                // start outranks a coincident mode press
                if (start_press) begin
                    if (pnl.door_closed) begin
                        state_d = P_ARM;
                        start_d = 1'b1;
                        error_d = 1'b0;
                        tmr_d   = ARM_LOAD;
                    end else begin
                        error_d = 1'b1;
                    end
                end else if (mode_press) begin
                    mode_d = next_mode(mode_q);
                end
            end
            P_ARM: begin
                if (pnl.wm_state != WM_IDLE) begin
                    state_d = P_RUN;
                end else if (tmr_q <= TMR_TC) begin
                    error_d = 1'b1;
                    state_d = P_IDLE;
                end
            end
            P_RUN: begin
                if (door_prev_q && !pnl.door_closed) begin
                    error_d = 1'b1;
                end
                if (pnl.wm_state == WM_IDLE) begin
                    state_d = P_DONE;
                    tmr_d   = UNLOCK_LOAD;
                end
            end
            P_DONE: begin
                if (tmr_q <= TMR_TC) begin
                    done_d  = 1'b1;
                    state_d = P_IDLE;
                end
            end
            default: state_d = P_IDLE;
        endcase
        door_lock_d = (state_d != P_IDLE);
        busy_d      = (state_d == P_ARM) || (state_d == P_RUN);
    end

    assign pnl.start     = start_q;
    assign pnl.mode      = mode_q;
    assign pnl.mode_led  = led_q;
    assign pnl.door_lock = door_lock_q;
    assign pnl.busy      = busy_q;
    assign pnl.done      = done_q;
    assign pnl.error     = error_q;

endmodule

// File: tb/tb_wm_control_panel.sv
// Directed bench for wm_control_panel with DEBOUNCE_CYCLES=4, ARM_TIMEOUT=8, UNLOCK_DELAY=4.
module tb_wm_control_panel;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   start_cnt = 0;
    int   base = 0;

    wm_control_panel_if pif();

    wm_control_panel #(
        .DEBOUNCE_CYCLES (4),
        .ARM_TIMEOUT     (8),
        .UNLOCK_DELAY    (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .pnl   (pif.master)
    );

    always #5 clk = ~clk;

    // counts start pulses using the value held over the preceding cycle
    always @(posedge clk) if (pif.start === 1'b1) start_cnt++;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [1:0] exp_mode [3];
        logic [2:0] exp_led  [3];
        exp_mode = '{2'b01, 2'b10, 2'b00};
        exp_led  = '{3'b010, 3'b100, 3'b001};

        pif.btn_start   = 1'b0;
        pif.btn_mode    = 1'b0;
        pif.door_closed = 1'b1;
        pif.wm_state    = 4'd0;
        reset           = 1'b1;
        step(3);
        chk("rst_start", 8'(pif.start), 8'h0);
        chk("rst_mode", 8'(pif.mode), 8'h0);
        chk("rst_led", 8'(pif.mode_led), 8'h1);
        chk("rst_lock", 8'(pif.door_lock), 8'h0);
        chk("rst_busy", 8'(pif.busy), 8'h0);
        chk("rst_done", 8'(pif.done), 8'h0);
        chk("rst_error", 8'(pif.error), 8'h0);
        reset = 1'b0;
        step(2);

        // mode cycling with exact press latency
        for (int i = 0; i < 3; i++) begin
            pif.btn_mode = 1'b1;
            step(6);
            chk("mode_early", 8'(pif.mode), 8'(exp_mode[(i + 2) % 3]));
            step(1);
            chk("mode_step", 8'(pif.mode), 8'(exp_mode[i]));
            chk("mode_led", 8'(pif.mode_led), 8'(exp_led[i]));
            pif.btn_mode = 1'b0;
            step(8);
        end
        chk("mode_no_start", 8'(start_cnt), 8'd0);

        // bounce rejection, then a clean hold that also runs into the arm timeout
        base = start_cnt;
        repeat (3) begin
            pif.btn_start = 1'b1;
            step(2);
            pif.btn_start = 1'b0;
            step(2);
        end
        chk("bounce_none", 8'(start_cnt - base), 8'd0);
        chk("bounce_idle", 8'(pif.busy), 8'h0);
        pif.btn_start = 1'b1;
        step(6);
        chk("hold_early", 8'(pif.start), 8'h0);
        step(1);
        chk("hold_start", 8'(pif.start), 8'h1);
        chk("arm_busy", 8'(pif.busy), 8'h1);
        chk("arm_lock", 8'(pif.door_lock), 8'h1);
        step(1);
        chk("start_width", 8'(pif.start), 8'h0);
        step(6);
        chk("arm_busy7", 8'(pif.busy), 8'h1);
        chk("arm_err7", 8'(pif.error), 8'h0);
        step(1);
        chk("tmo_error", 8'(pif.error), 8'h1);
        chk("tmo_busy", 8'(pif.busy), 8'h0);
        chk("tmo_lock", 8'(pif.door_lock), 8'h0);
        step(5);
        chk("hold_one", 8'(start_cnt - base), 8'd1);
        pif.btn_start = 1'b0;
        step(8);

        // door open
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("rst_clear_err", 8'(pif.error), 8'h0);
        step(1);
        pif.door_closed = 1'b0;
        base = start_cnt;
        pif.btn_start = 1'b1;
        step(7);
        chk("open_start", 8'(pif.start), 8'h0);
        chk("open_error", 8'(pif.error), 8'h1);
        chk("open_busy", 8'(pif.busy), 8'h0);
        chk("open_lock", 8'(pif.door_lock), 8'h0);
        pif.btn_start = 1'b0;
        step(8);
        chk("open_no_pulse", 8'(start_cnt - base), 8'd0);
        chk("open_sticky", 8'(pif.error), 8'h1);
        pif.door_closed = 1'b1;
        pif.btn_start = 1'b1;
        step(7);
        chk("close_start", 8'(pif.start), 8'h1);
        chk("close_err_clr", 8'(pif.error), 8'h0);
        chk("close_lock", 8'(pif.door_lock), 8'h1);
        pif.btn_start = 1'b0;
        step(8);
        chk("tmo2_error", 8'(pif.error), 8'h1);
        chk("tmo2_busy", 8'(pif.busy), 8'h0);
        chk("tmo2_lock", 8'(pif.door_lock), 8'h0);
        step(8);

        // full cycle in heavy mode
        repeat (2) begin
            pif.btn_mode = 1'b1;
            step(7);
            pif.btn_mode = 1'b0;
            step(8);
        end
        chk("full_mode", 8'(pif.mode), 8'h2);
        chk("full_led", 8'(pif.mode_led), 8'h4);
        base = start_cnt;
        pif.btn_start = 1'b1;
        step(7);
        chk("full_start", 8'(pif.start), 8'h1);
        pif.btn_start = 1'b0;
        step(2);
        pif.wm_state = 4'd1;
        chk("full_arm_busy", 8'(pif.busy), 8'h1);
        step(1);
        chk("full_run_busy", 8'(pif.busy), 8'h1);
        pif.btn_mode = 1'b1;
        step(7);
        pif.btn_mode = 1'b0;
        step(8);
        chk("run_mode_frozen", 8'(pif.mode), 8'h2);
        chk("run_led_frozen", 8'(pif.mode_led), 8'h4);
        chk("run_lock", 8'(pif.door_lock), 8'h1);
        step(35);
        chk("run_busy", 8'(pif.busy), 8'h1);
        chk("run_error", 8'(pif.error), 8'h0);
        pif.wm_state = 4'd0;
        step(1);
        chk("done_busy", 8'(pif.busy), 8'h0);
        chk("done_lock0", 8'(pif.door_lock), 8'h1);
        chk("done_pulse0", 8'(pif.done), 8'h0);
        step(3);
        chk("done_lock3", 8'(pif.door_lock), 8'h1);
        chk("done_pulse3", 8'(pif.done), 8'h0);
        step(1);
        chk("unlock", 8'(pif.door_lock), 8'h0);
        chk("done_pulse", 8'(pif.done), 8'h1);
        step(1);
        chk("done_width", 8'(pif.done), 8'h0);
        chk("full_one_start", 8'(start_cnt - base), 8'd1);

        // door opened during RUN, then reset mid-run
        pif.btn_start = 1'b1;
        step(7);
        chk("rr_start", 8'(pif.start), 8'h1);
        pif.btn_start = 1'b0;
        pif.wm_state = 4'd1;
        step(4);
        pif.door_closed = 1'b0;
        step(1);
        chk("door_fall_err", 8'(pif.error), 8'h1);
        chk("door_fall_busy", 8'(pif.busy), 8'h1);
        chk("door_fall_lock", 8'(pif.door_lock), 8'h1);
        pif.door_closed = 1'b1;
        step(2);
        chk("run_err_sticky", 8'(pif.error), 8'h1);
        reset = 1'b1;
        step(1);
        chk("mid_rst_mode", 8'(pif.mode), 8'h0);
        chk("mid_rst_led", 8'(pif.mode_led), 8'h1);
        chk("mid_rst_lock", 8'(pif.door_lock), 8'h0);
        chk("mid_rst_busy", 8'(pif.busy), 8'h0);
        chk("mid_rst_error", 8'(pif.error), 8'h0);
        chk("mid_rst_start", 8'(pif.start), 8'h0);
        reset = 1'b0;
        pif.wm_state = 4'd0;
        step(3);
        chk("post_rst_idle", 8'(pif.busy), 8'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wm_control_panel.md
Name: wm_control_panel

Overview:
Front-panel controller that sits directly upstream of washing_machine and drives its start and mode inputs. It synchronises and debounces the raw START and MODE push-buttons and maintains the selected wash mode. It issues a single-cycle start pulse only when the door is closed, then tracks the machine's state output to drive the door lock, busy indication and completion/error flags.

Parameters:
DEBOUNCE_CYCLES, 16, number of consecutive cycles a synchronised button level must be stable before it is accepted (min 2).
ARM_TIMEOUT, 8, cycles to wait in ARM for the machine to leave idle before flagging an error.
UNLOCK_DELAY, 4, cycles the door stays locked after the machine returns to idle.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
btn_start  in  1  raw START button, asynchronous, active-high
btn_mode  in  1  raw MODE button, asynchronous, active-high
door_closed  in  1  door sensor, 1 = closed (already synchronous)
wm_state  in  4  state output of washing_machine
start  out  1  one-cycle start pulse to washing_machine
mode  out  2  selected mode to washing_machine (00 light, 01 normal, 10 heavy)
mode_led  out  3  one-hot mode display ({heavy, normal, light})
door_lock  out  1  door lock solenoid
busy  out  1  cycle in progress (ARM or RUN)
done  out  1  one-cycle pulse when DONE exits to IDLE
error  out  1  sticky fault flag

Behaviour:
- Reset values: start=0, mode=00, mode_led=001, door_lock=0, busy=0, done=0, error=0, FSM=IDLE, debounce counters=0, debounced levels=0.
- Buttons: 2-flop synchroniser, then debounce. The debounced level changes only after DEBOUNCE_CYCLES consecutive equal synchronised samples. A press pulse is 1 cycle on each debounced 0->1 edge. Holding a button gives exactly one press. Bounces shorter than DEBOUNCE_CYCLES give none.
- Press latency: the press pulse is asserted 2+DEBOUNCE_CYCLES edges after btn first samples high. All outputs are registered and change one cycle after the press pulse.
- FSM IDLE:
  - Mode press: mode steps 00->01->10->00. 11 is never produced. mode_led follows.
  - Start press with door_closed=1: go to ARM, start=1 for exactly that one cycle, door_lock=1, error cleared.
  - Start press with door_closed=0: error=1, stay in IDLE, no start pulse.
  - Simultaneous start and mode press: start wins and mode is unchanged.
- FSM ARM: busy=1, door_lock=1.
  - wm_state != WM_IDLE (4'd0): go to RUN.
  - After ARM_TIMEOUT cycles still idle: error=1, door_lock=0, go to IDLE.
- FSM RUN: busy=1, door_lock=1. Mode and start presses are ignored; mode is frozen.
  - door_closed falling: error=1, stay in RUN (no abort path exists).
  - wm_state == WM_IDLE: go to DONE.
- FSM DONE: busy=0, door_lock=1, presses ignored. After UNLOCK_DELAY cycles: done=1 for one cycle, door_lock=0, go to IDLE.
- error clearing: sticky; cleared only by reset or an accepted start.
- Reset mid-operation: all state returns to reset values in the next cycle, regardless of FSM state.
- Timers are sized by $clog2 of their parameter+1 and saturate; they never wrap.

Decomposition:
- Package wm_pkg:
  - mode typedef: WM_LIGHT=2'b00, WM_NORMAL=2'b01, WM_HEAVY=2'b10.
  - Constant WM_IDLE=4'd0.
  - Panel state enum {P_IDLE, P_ARM, P_RUN, P_DONE}.
  - Shared with washing_machine.
- Sub-module wm_debounce (parameter DEBOUNCE_CYCLES; ports clk, reset, raw, level, press), instantiated once per button.

Test Plan (DEBOUNCE_CYCLES=4, ARM_TIMEOUT=8, UNLOCK_DELAY=4):
- Mode cycling: three clean mode presses -> mode 01, 10, 00; mode_led 010, 100, 001; start stays 0.
- Bounce rejection: btn_start toggles every 2 cycles for 12 cycles, then is held high for 20 with door closed -> exactly one start pulse, 1 cycle wide, asserted 7 edges after the stable-high begins.
- Door open: door_closed=0, start press -> error=1, state stays IDLE, start never high. Then close the door and press start -> error=0 and a start pulse is issued.
- Full cycle: mode=10, start press, wm_state driven to 4'd1 two cycles later, then to 4'd0 after 50 cycles -> busy=1 throughout ARM/RUN, mode presses ignored, door_lock drops 4 cycles after idle with a coincident 1-cycle done.
- Arm timeout: start press with wm_state held at 0 -> after 8 cycles error=1, door_lock=0, busy=0, FSM back in IDLE.
- Reset mid-RUN: reset asserted for 1 cycle -> next cycle mode=00, door_lock=0, busy=0, error=0, start=0.
